freq_gate_meter: RTL

FREQ_GATE_METER -- requirements
Module: freq_gate_meter

---
 rtl/freq_gate_meter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/freq_gate_meter.sv
// Gated frequency meter: counts EDGE_i pulses over a fixed window of
// GATE_CYCLES clocks, then publishes the (saturating) count for one cycle.
module freq_gate_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               CLK_IN,
  input  logic               RST_N,
  input  logic               EN_i,
  input  logic               EDGE_i,
  output logic [COUNT_W-1:0] COUNT_o,
  output logic               OVF_o,
  output logic               VALID_o,
  output logic               BUSY_o,
  output logic [7:0]         LED_o
);

  localparam int unsigned TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] ACC_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GATE  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TIMER_W-1:0]   r_timer;
  logic [COUNT_W-1:0]   r_acc;
  logic                 r_ovf;
  logic [COUNT_W-1:0]   r_count;
  logic                 r_cnt_ovf;
  logic                 r_valid;
  logic                 r_busy;
  logic [7:0]           r_led;

  logic                 w_last;
  logic                 w_acc_full;
  logic [COUNT_W-1:0]   w_acc_sum;
  logic                 w_ovf_sum;
  logic                 w_gate_hold;
  logic                 w_gate_done;
  logic [7:0]           w_led_cnt;

  // Window bookkeeping: last timer step, saturating accumulate including this cycle's edge
  always_comb begin
    w_last      = (r_timer == TIMER_LAST);
    w_acc_full  = (r_acc == ACC_MAX);
    w_acc_sum   = r_acc;
    if (EDGE_i && !w_acc_full) begin
      w_acc_sum = r_acc + COUNT_W'(1);
    end
    w_ovf_sum   = r_ovf | (EDGE_i & w_acc_full);
    w_gate_hold = (r_state == S_GATE) && (w_state_nxt == S_GATE);
    w_gate_done = (r_state == S_GATE) && (w_state_nxt == S_LATCH);
  end

  // Display value: low byte of the count, zero-extended for narrow counters
  generate
    if (COUNT_W >= 8) begin : g_led_wide
      assign w_led_cnt = w_acc_sum[7:0];
    end else begin : g_led_narrow
      assign w_led_cnt = {{(8 - COUNT_W){1'b0}}, w_acc_sum};
    end
  endgenerate

  // Next-state logic; dropping EN_i aborts the window even on its last cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (EN_i) begin
          w_state_nxt = S_GATE;
        end
      end
      S_GATE: begin
        if (!EN_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        w_state_nxt = EN_i ? S_GATE : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Timer/accumulator advance only while staying in GATE; any other path clears them
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_timer <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_gate_hold) begin
      r_timer <= r_timer + TIMER_W'(1);
      r_acc   <= w_acc_sum;
      r_ovf   <= w_ovf_sum;
    end else begin
      r_timer <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end
  end

  // Result registers change only when a window completes into LATCH
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_count   <= '0;
      r_cnt_ovf <= 1'b0;
      r_led     <= 8'h00;
    end else if (w_gate_done) begin
      r_count   <= w_acc_sum;
      r_cnt_ovf <= w_ovf_sum;
      r_led     <= w_ovf_sum ? 8'hFF : w_led_cnt;
    end
  end

  // Registered status flags track the state being entered
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt == S_GATE);
      r_valid <= (w_state_nxt == S_LATCH);
    end
  end

  assign COUNT_o = r_count;
  assign OVF_o   = r_cnt_ovf;
  assign VALID_o = r_valid;
  assign BUSY_o  = r_busy;
  assign LED_o   = r_led;

endmodule
